pico_bus_ram16_responder: RTL
=============================

// Module: pico_bus_ram16_responder
// PURPOSE
//  Responder on the PicoRV32-style shared CPU bus (mem_valid/mem_ready/mem_addr/mem_wdata/mem_wstrb/mem_rdata).
//  Decodes its own address window and serves 32-bit word accesses from a 16-bit-wide synchronous RAM
//  (iCE40 SPRAM-style: nibble write mask, fixed read latency). Each access becomes one or two 16-bit RAM cycles.
//  Sits beside the other bus responders; mem_rdata is zero when idle, so responder outputs are OR-combined.
// PARAMETERS
//  BASE_ADDR    32'h0002_0000  window base; hit = (mem_addr & ADDR_MASK) == BASE_ADDR
//  ADDR_MASK    32'hfffe_0000  window decode mask
//  RAM_AW       14             RAM half-word address width
//  RAM_LATENCY  1              cycles from ram_addr presented to ram_rdata valid (1..3)
// PORTS
//  clk        in   1       system clock
//  reset      in   1       synchronous, active-high
//  mem_valid  in   1       initiator request, held until mem_ready
//  mem_addr   in   32      byte address; [1:0] ignored (word accesses only)
//  mem_wdata  in   32      write data
//  mem_wstrb  in   4       byte strobes; 0 = read
//  mem_ready  out  1       one-cycle completion pulse
//  mem_rdata  out  32      read data, valid only with mem_ready, else 0
//  ram_addr   out  RAM_AW  half-word address = {mem_addr[RAM_AW:2], half}
//  ram_wdata  out  16      write half-word
//  ram_we     out  1       write enable
//  ram_mask   out  4       nibble write mask (byte strobe b -> 2 nibble bits)
//  ram_rdata  in   16      read half-word
// BEHAVIOUR
//  - Clock clk, reset synchronous active-high (fixed). Reset: mem_ready=0, mem_rdata=0, ram_we=0, ram_mask=0,
//    ram_addr=0, ram_wdata=0, FSM->IDLE, latency pipe cleared. Reset mid-access drops it; no ready issued.
//  - All outputs registered. Request accepted in IDLE when mem_valid && hit; non-hits are ignored entirely.
//  - States: IDLE, ISSUE_LO, ISSUE_HI, WAIT_RD, DONE, GUARD.
//    IDLE -> ISSUE_LO (read, or write with wstrb[1:0]!=0) | ISSUE_HI (write with wstrb[1:0]==0).
//    ISSUE_LO: ram_addr half=0, ram_wdata=wdata[15:0], ram_we=write, ram_mask from wstrb[1:0].
//      -> ISSUE_HI if read or wstrb[3:2]!=0, else DONE.
//    ISSUE_HI: half=1, ram_wdata=wdata[31:16], mask from wstrb[3:2]. -> WAIT_RD (read) | DONE (write).
//    WAIT_RD: capture lo/hi half-words RAM_LATENCY cycles after each issue; -> DONE when hi captured.
//    DONE: mem_ready=1 for exactly one cycle; mem_rdata={hi,lo} for reads, 0 for writes. -> GUARD.
//    GUARD: one cycle ignoring mem_valid (initiator drops valid the cycle after ready) -> IDLE.
//  - ram_we/ram_mask asserted only during the cycle of each issue; 0 otherwise. Reads drive ram_mask=0.
//  - Latency, valid sampled in IDLE at cycle T: full write ready at T+3; single-half write at T+2;
//    read ready at T+3+RAM_LATENCY.
//  - Address, wdata and wstrb latched in IDLE; input changes mid-access have no effect.
//  - mem_valid dropping mid-access (protocol violation) does not abort; ready still pulses once.
//  - Window edges: first and last word of window hit; BASE_ADDR-4 and BASE_ADDR+window do not.
// STRUCTURE
//  - State encodings and nibble-mask expansion function go in the shared bus header (cpu_bus_defs.vh)
//    for reuse by other RAM responders.
//  - Sub-module ram_read_delay: RAM_LATENCY-deep shift of {issue_valid, half} tags marking capture cycles.
// TESTING
//  1. Write 0xdeadbeef, wstrb=4'hf, @BASE -> ready at T+3; RAM[0]=0xbeef, RAM[1]=0xdead, masks 4'hf both.
//  2. Read back @BASE, RAM_LATENCY=1 -> ready at T+4, mem_rdata=0xdeadbeef; mem_rdata=0 other cycles.
//  3. Byte write 0x55 wstrb=4'b0100 @BASE -> one RAM cycle, half=1, mask 4'b0011, ready at T+2;
//     readback 0xde55beef.
//  4. Access at BASE_ADDR-4 with mem_valid held 20 cycles -> no ready, ram_we never set.
//  5. Back-to-back reads (valid re-asserted in GUARD cycle) -> second accepted only after GUARD, one ready each.
//  6. Reset asserted in ISSUE_HI of a write -> no ready, ram_we=0 next cycle, next read completes normally.

Source files
------------

// File: rtl/pico_bus_ram16_responder_pkg.sv
// Shared definitions for 16-bit-RAM bus responders: FSM encoding and write-mask helpers.

package pico_bus_ram16_responder_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIssueLo,
    StIssueHi,
    StWaitRd,
    StDone,
    StGuard
  } state_e;

  // Each byte strobe enables the two nibbles of that byte in the RAM half-word.
  function automatic logic [3:0] nibble_mask(input logic [1:0] strb);
    return {strb[1], strb[1], strb[0], strb[0]};
  endfunction

endpackage

// File: rtl/pico_bus_ram16_responder_ram_read_delay.sv
// Shift register of read-issue tags; the output tag marks the cycle in which the RAM read data
// belonging to that issue is present on ram_rdata.

module pico_bus_ram16_responder_ram_read_delay #(
  parameter int unsigned Latency = 1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic tag_valid_i,
  input  logic tag_half_i,
  output logic tag_valid_o,
  output logic tag_half_o
);

  logic [Latency-1:0] valid_q, valid_d;
  logic [Latency-1:0] half_q, half_d;

  always_comb begin
    valid_d    = valid_q;
    half_d     = half_q;
    valid_d[0] = tag_valid_i;
    half_d[0]  = tag_half_i;
    for (int i = 1; i < int'(Latency); i++) begin
      valid_d[i] = valid_q[i-1];
      half_d[i]  = half_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= '0;
      half_q  <= '0;
    end else begin
      valid_q <= valid_d;
      half_q  <= half_d;
    end
  end

  assign tag_valid_o = valid_q[Latency-1];
  assign tag_half_o  = half_q[Latency-1];

endmodule

// File: rtl/pico_bus_ram16_responder.sv
// PicoRV32-style bus responder serving 32-bit word accesses from a 16-bit synchronous RAM,
// splitting each access into one or two half-word RAM cycles. All outputs are registered.

module pico_bus_ram16_responder
  import pico_bus_ram16_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0002_0000,
  parameter logic [31:0] ADDR_MASK   = 32'hfffe_0000,
  parameter int unsigned RAM_AW      = 14,
  parameter int unsigned RAM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_valid,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_wstrb,
  output logic              mem_ready,
  output logic [31:0]       mem_rdata,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [15:0]       ram_wdata,
  output logic              ram_we,
  output logic [3:0]        ram_mask,
  input  logic [15:0]       ram_rdata
);

  localparam int unsigned WordAw = RAM_AW - 1;

  state_e state_q, state_d;

  logic [WordAw-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [15:0]       lo_q, lo_d;
  logic              rd_issue_q, rd_issue_d;

  logic              mem_ready_q, mem_ready_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;
  logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
  logic [15:0]       ram_wdata_q, ram_wdata_d;
  logic              ram_we_q, ram_we_d;
  logic [3:0]        ram_mask_q, ram_mask_d;

  logic              hit;
  logic [WordAw-1:0] cur_waddr;
  logic [31:0]       cur_wdata;
  logic [3:0]        cur_wstrb;
  logic              cur_wr;
  logic              issue_half;
  logic [1:0]        half_strb;
  logic              tag_valid;
  logic              tag_half;

  assign hit = (mem_addr & ADDR_MASK) == BASE_ADDR;

  pico_bus_ram16_responder_ram_read_delay #(
    .Latency (RAM_LATENCY)
  ) u_ram_read_delay (
    .clk_i       (clk),
    .reset_i     (reset),
    .tag_valid_i (rd_issue_q),
    .tag_half_i  (ram_addr_q[0]),
    .tag_valid_o (tag_valid),
    .tag_half_o  (tag_half)
  );

  // Request latch and sequencing. cur_* is the access being issued: the live bus in IDLE,
  // the latched copy afterwards, so the first RAM cycle can be registered at acceptance.
  always_comb begin
    state_d   = state_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    cur_waddr = waddr_q;
    cur_wdata = wdata_q;
    cur_wstrb = wstrb_q;
    unique case (state_q)
      StIdle: begin
        if (mem_valid && hit) begin
          waddr_d   = mem_addr[RAM_AW:2];
          wdata_d   = mem_wdata;
          wstrb_d   = mem_wstrb;
          cur_waddr = mem_addr[RAM_AW:2];
          cur_wdata = mem_wdata;
          cur_wstrb = mem_wstrb;
          state_d   = (mem_wstrb != 4'b0 && mem_wstrb[1:0] == 2'b0) ? StIssueHi : StIssueLo;
        end
      end
      StIssueLo: state_d = (wstrb_q == 4'b0 || wstrb_q[3:2] != 2'b0) ? StIssueHi : StDone;
      StIssueHi: state_d = (wstrb_q == 4'b0) ? StWaitRd : StDone;
      StWaitRd: begin
        if (tag_valid && tag_half) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StGuard;
      StGuard: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // RAM strobes exist only for the cycle of each issue; address and data simply hold.
  always_comb begin
    cur_wr      = cur_wstrb != 4'b0;
    issue_half  = state_d == StIssueHi;
    half_strb   = issue_half ? cur_wstrb[3:2] : cur_wstrb[1:0];
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;
    ram_mask_d  = 4'b0;
    rd_issue_d  = 1'b0;
    if (state_d == StIssueLo || state_d == StIssueHi) begin
      ram_addr_d  = {cur_waddr, issue_half};
      ram_wdata_d = issue_half ? cur_wdata[31:16] : cur_wdata[15:0];
      ram_we_d    = cur_wr;
      ram_mask_d  = cur_wr ? nibble_mask(half_strb) : 4'b0;
      rd_issue_d  = !cur_wr;
    end
    lo_d        = (tag_valid && !tag_half) ? ram_rdata : lo_q;
    mem_ready_d = state_d == StDone;
    mem_rdata_d = (state_q == StWaitRd && state_d == StDone) ? {ram_rdata, lo_q} : 32'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      waddr_q     <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      lo_q        <= '0;
      rd_issue_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      mem_rdata_q <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_we_q    <= 1'b0;
      ram_mask_q  <= '0;
    end else begin
      state_q     <= state_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      lo_q        <= lo_d;
      rd_issue_q  <= rd_issue_d;
      mem_ready_q <= mem_ready_d;
      mem_rdata_q <= mem_rdata_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
      ram_mask_q  <= ram_mask_d;
    end
  end

  assign mem_ready = mem_ready_q;
  assign mem_rdata = mem_rdata_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_we    = ram_we_q;
  assign ram_mask  = ram_mask_q;

endmodule
